// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : change_dispenser_pkg
// Brief   : Denomination codes, FSM state encodings and coin-select type
//           shared by the change dispenser and the control unit.
// Rev     : 1.0  initial release
// ============================================================================
package change_dispenser_pkg;

    // Coin values in 10-sen units
    localparam logic [2:0] DEN50 = 3'd5;
    localparam logic [2:0] DEN20 = 3'd2;
    localparam logic [2:0] DEN10 = 3'd1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EJECT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_FAIL   = 3'd5;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_50   = 2'd1,
        COIN_20   = 2'd2,
        COIN_10   = 2'd3
    } coin_e;

    function automatic logic [2:0] coin_value(input coin_e c);
        logic [2:0] v;
        case (c)
            COIN_50: v = DEN50;
            COIN_20: v = DEN20;
            COIN_10: v = DEN10;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_timer.sv
`default_nettype none
// ============================================================================
// Module  : dispense_timer
// Brief   : Loadable down-counter shared by the eject-pulse and settle-gap
//           phases; expired_o is high while the count sits at zero.
// Rev     : 1.0  initial release
// ============================================================================
module dispense_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : change_dispenser
// Brief   : Pays a change amount out as 50/20/10-sen coins, one solenoid
//           pulse at a time. Define CHANGE_INVENTORY_EN for per-tube coin
//           counting, service reload and the shortfall (err/short) path.
// Rev     : 1.0  initial release
// ============================================================================
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W     = 6,
    parameter int CNT_W     = 6,
    parameter int TUBE_CAP  = 40,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [AMT_W-1:0] amount_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [AMT_W-1:0] short_o,
    output logic             eject50_o,
    output logic             eject20_o,
    output logic             eject10_o,
    input  logic             reload_i
);

    localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [2:0]       state_q, state_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    coin_e            coin_q, coin_d;
    coin_e            pick;
    logic             avail50, avail20, avail10;
    logic             accept;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expired;

    assign accept = req_i && ready_o;

    // Greedy choice over whatever tubes still hold coins
    always_comb begin
        pick = COIN_NONE;
        if (rem_q >= AMT_W'(DEN50) && avail50) begin
            pick = COIN_50;
        end else if (rem_q >= AMT_W'(DEN20) && avail20) begin
            pick = COIN_20;
        end else if (rem_q >= AMT_W'(DEN10) && avail10) begin
            pick = COIN_10;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        coin_d   = coin_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d   = amount_i;
                    state_d = (amount_i == '0) ? S_DONE : S_SELECT;
                end
            end
            S_SELECT: begin
                if (pick == COIN_NONE) begin
                    state_d = S_FAIL;
                end else begin
                    rem_d    = rem_q - AMT_W'(coin_value(pick));
                    coin_d   = pick;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                    state_d  = S_EJECT;
                end
            end
            S_EJECT: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYC - 1);
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_expired) begin
                    state_d = (rem_q == '0) ? S_DONE : S_SELECT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            coin_q  <= COIN_NONE;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            coin_q  <= coin_d;
        end
    end

    dispense_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

`ifdef CHANGE_INVENTORY_EN
    localparam logic [CNT_W-1:0] CAP = CNT_W'(TUBE_CAP);

    logic [CNT_W-1:0] cnt50_q, cnt20_q, cnt10_q;
    logic [AMT_W-1:0] short_q;

    assign avail50 = (cnt50_q != '0);
    assign avail20 = (cnt20_q != '0);
    assign avail10 = (cnt10_q != '0);

    // Coin is debited in SELECT, the same cycle remaining is reduced
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt50_q <= CAP;
            cnt20_q <= CAP;
            cnt10_q <= CAP;
        end else if (state_q == S_IDLE && reload_i) begin
            cnt50_q <= CAP;
            cnt20_q <= CAP;
            cnt10_q <= CAP;
        end else if (state_q == S_SELECT) begin
            case (pick)
                COIN_50: cnt50_q <= cnt50_q - CNT_W'(1);
                COIN_20: cnt20_q <= cnt20_q - CNT_W'(1);
                COIN_10: cnt10_q <= cnt10_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            short_q <= '0;
        end else if (accept) begin
            short_q <= '0;
        end else if (state_q == S_SELECT && pick == COIN_NONE) begin
            short_q <= rem_q;
        end
    end

    assign err_o   = (state_q == S_FAIL);
    assign short_o = short_q;
`else
    logic w_unused_reload;

    assign avail50         = 1'b1;
    assign avail20         = 1'b1;
    assign avail10         = 1'b1;
    assign w_unused_reload = reload_i;
    assign err_o           = 1'b0;
    assign short_o         = '0;
`endif

    assign ready_o   = (state_q == S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign eject50_o = (state_q == S_EJECT) && (coin_q == COIN_50);
    assign eject20_o = (state_q == S_EJECT) && (coin_q == COIN_20);
    assign eject10_o = (state_q == S_EJECT) && (coin_q == COIN_10);

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : tb_change_dispenser
// Brief   : Self-checking bench for change_dispenser against a cycle-trace
//           model built from the payout rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_change_dispenser;

    localparam int P   = 4;
    localparam int G   = 8;
    localparam int CAP = 40;
`ifdef CHANGE_INVENTORY_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       req_i;
    logic [5:0] amount_i;
    logic       ready_o;
    logic       done_o;
    logic       err_o;
    logic [5:0] short_o;
    logic       eject50_o;
    logic       eject20_o;
    logic       eject10_o;
    logic       reload_i;

    int n_tests;
    int n_fail;

    // Model state: coins left per tube (50,20,10), expected short, cycle trace
    int         m_cnt[3];
    int         exp_short;
    logic [5:0] exp_q[$];

    change_dispenser dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .amount_i  (amount_i),
        .ready_o   (ready_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .short_o   (short_o),
        .eject50_o (eject50_o),
        .eject20_o (eject20_o),
        .eject10_o (eject10_o),
        .reload_i  (reload_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] obs();
        return {eject50_o, eject20_o, eject10_o, done_o, err_o, ready_o};
    endfunction

    function automatic int cval(input int j);
        return (j == 0) ? 5 : ((j == 1) ? 2 : 1);
    endfunction

    task automatic model_refill();
        for (int j = 0; j < 3; j++) m_cnt[j] = CAP;
    endtask

    // Expected {e50,e20,e10,done,err,ready} for every cycle after the handshake edge
    task automatic build_trace(input int amt);
        int rem;
        int k;
        bit fin;
        exp_q.delete();
        rem       = amt;
        exp_short = 0;
        fin       = (amt == 0);
        if (amt == 0) exp_q.push_back(6'b000100);
        while (!fin) begin
            k = -1;
            for (int j = 0; j < 3; j++)
                if (k < 0 && cval(j) <= rem && (!INV || m_cnt[j] > 0)) k = j;
            exp_q.push_back(6'b000000);
            if (k < 0) begin
                exp_q.push_back(6'b000010);
                exp_short = rem;
                fin = 1'b1;
            end else begin
                rem = rem - cval(k);
                if (INV) m_cnt[k] = m_cnt[k] - 1;
                repeat (P) exp_q.push_back(6'b100000 >> k);
                repeat (G) exp_q.push_back(6'b000000);
                if (rem == 0) begin
                    exp_q.push_back(6'b000100);
                    fin = 1'b1;
                end
            end
        end
        exp_q.push_back(6'b000001);
    endtask

    task automatic do_txn(input int amt, input bit hold, input int hold_amt,
                          input bit rl_with_req, input bit rl_during);
        logic [5:0] got;
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_before amt=%0d got=%b exp=1", amt, ready_o);
        end
        req_i    = 1'b1;
        amount_i = 6'(amt);
        if (rl_with_req) begin
            reload_i = 1'b1;
            model_refill();
        end
        build_trace(amt);
        @(posedge clk); #1;
        reload_i = rl_during;
        if (hold) amount_i = 6'(hold_amt);
        else      req_i = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            got = obs();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL trace amt=%0d cyc=%0d got=%b exp=%b", amt, i, got, exp_q[i]);
            end
        end
        reload_i = 1'b0;
        n_tests++;
        if (short_o !== 6'(exp_short)) begin
            n_fail++;
            $display("FAIL short amt=%0d got=%0d exp=%0d", amt, short_o, exp_short);
        end
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        @(posedge clk); #1;
        reload_i = 1'b0;
        model_refill();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=000001", obs());
        end
        n_tests++;
        if (short_o !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_short got=%0d exp=0", short_o);
        end
        rst = 1'b0;
        model_refill();
        exp_short = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_seq8();
        do_txn(8, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        do_txn(0, 1'b0, 0, 1'b0, 1'b0);
        do_txn(0, 1'b0, 0, 1'b0, 1'b0);
    endtask

`ifdef CHANGE_INVENTORY_EN
    task automatic test_exhaust();
        do_reload();
        repeat (CAP) do_txn(1, 1'b0, 0, 1'b0, 1'b0);
        repeat (CAP) do_txn(2, 1'b0, 0, 1'b0, 1'b0);
        do_txn(6, 1'b0, 0, 1'b0, 1'b0);
        n_tests++;
        if (short_o !== 6'd1) begin
            n_fail++;
            $display("FAIL short_after_exhaust got=%0d exp=1", short_o);
        end
        do_reload();
        repeat (CAP) do_txn(5, 1'b0, 0, 1'b0, 1'b0);
        do_txn(6, 1'b0, 0, 1'b0, 1'b0);
        do_txn(5, 1'b0, 0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_reset_mid();
        req_i    = 1'b1;
        amount_i = 6'd7;
        @(posedge clk); #1;
        req_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        n_tests++;
        if (obs() !== 6'b010000) begin
            n_fail++;
            $display("FAIL second_eject got=%b exp=010000", obs());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (obs() !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_mid got=%b exp=000001", obs());
        end
        model_refill();
        exp_short = 0;
        do_txn(7, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_txn(4, 1'b1, 3, 1'b0, 1'b1);
        do_txn(3, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int gap;
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            if ($urandom_range(0, 7) == 0) do_reload();
            do_txn($urandom_range(0, 63), 1'b0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req_i    = 1'b0;
        amount_i = 6'd0;
        reload_i = 1'b0;
        test_reset();
        test_seq8();
        test_zero();
`ifdef CHANGE_INVENTORY_EN
        test_exhaust();
`endif
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout waiting for bench completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
